// File: rtl/fanout_broadcast_buffer_pkg.sv
// Shared definitions for the fanout broadcast buffer and the fanout-ready hash.
// Both blocks must use branch_active() so they agree on which branches participate.
package fanout_broadcast_buffer_pkg;

   localparam int unsigned DefNumOut = 20;
   localparam int unsigned DefDataW  = 17;
   localparam int unsigned DefCfgW   = 8;
   localparam int unsigned DefSelBit = 5;
   localparam int unsigned DefCntW   = 16;

   typedef struct packed {
      logic        stop;
      logic [15:0] value;
   } token_t;

   function automatic logic branch_active(input logic               en,
                                          input logic [DefCfgW-1:0] cfg,
                                          input int unsigned        sel);
      return en & cfg[sel];
   endfunction

endpackage

// File: rtl/fanout_fifo2.sv
// Two-entry FIFO with 1-bit pointers and an explicit 0..2 occupancy count.
// Push while full or pop while empty is prevented by the caller.
module fanout_fifo2
   import fanout_broadcast_buffer_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic [1:0]        count
);

   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/fanout_broadcast_buffer.sv
// Delivers each buffered token to every active branch, popping the head once all
// active branches have accepted it; the done mask tracks acceptance for the head only.
module fanout_broadcast_buffer
   import fanout_broadcast_buffer_pkg::*;
#(
   parameter int unsigned NUM_OUT = DefNumOut,
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned CFG_W   = DefCfgW,
   parameter int unsigned SEL_BIT = DefSelBit,
   parameter int unsigned CNT_W   = DefCntW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_OUT-1:0]       out_en,
   input  logic [NUM_OUT*CFG_W-1:0] out_cfg,
   output logic [DATA_W-1:0]        out_data,
   output logic [NUM_OUT-1:0]       out_valid,
   input  logic [NUM_OUT-1:0]       out_ready,
   output logic [CNT_W-1:0]         xfer_count
);

   logic [1:0]         count;
   logic               push, pop, head_valid, complete;
   logic [NUM_OUT-1:0] act, fire, sat;
   logic [NUM_OUT-1:0] done_q, done_d;
   logic [CNT_W-1:0]   xfer_count_q, xfer_count_d;

   fanout_fifo2 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data (in_data),
      .rd_data (out_data),
      .count   (count)
   );

   always_comb begin
      act = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         act[i] = branch_active(out_en[i], out_cfg[i*CFG_W +: CFG_W], SEL_BIT);
      end
   end

   assign in_ready   = (count != 2'd2) & ~reset;
   assign push       = in_valid & in_ready;
   // Gated by reset so stale entries are never presented while reset is held.
   assign head_valid = (count != 2'd0) & ~reset;
   assign out_valid  = {NUM_OUT{head_valid}} & act & ~done_q;
   assign fire       = out_valid & out_ready;
   // Inactive branches count as satisfied, so an empty act mask drops the token at once.
   assign sat        = done_q | fire | ~act;
   assign complete   = head_valid & (&sat);
   assign pop        = complete;

   always_comb begin
      done_d       = complete ? '0 : (done_q | fire);
      xfer_count_d = xfer_count_q + CNT_W'(complete);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done_q       <= '0;
         xfer_count_q <= '0;
      end else begin
         done_q       <= done_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_fanout_broadcast_buffer.sv
// Directed bench for fanout_broadcast_buffer; expected values are worked out by hand
// per cycle. Inputs change 1 time unit after the rising edge, outputs are read on the falling edge.
module tb_fanout_broadcast_buffer;

   localparam int NumOut = 20;
   localparam int DataW  = 17;
   localparam int CfgW   = 8;
   localparam int CntW   = 16;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [DataW-1:0]        in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic [NumOut-1:0]       out_en;
   logic [NumOut*CfgW-1:0]  out_cfg;
   logic [DataW-1:0]        out_data;
   logic [NumOut-1:0]       out_valid;
   logic [NumOut-1:0]       out_ready;
   logic [CntW-1:0]         xfer_count;

   int n_checks = 0;
   int n_errors = 0;

   fanout_broadcast_buffer dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_en     (out_en),
      .out_cfg    (out_cfg),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .xfer_count (xfer_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Branch 9 always has the select bit but is disabled; odd inactive branches carry
   // every other config bit so only bit 5 may mark a participant.
   task automatic set_act(input logic [NumOut-1:0] m);
      for (int i = 0; i < NumOut; i++) begin
         out_en[i]             = 1'b1;
         out_cfg[i*CfgW +: CfgW] = m[i] ? 8'h20 : ((i % 2 == 1) ? 8'hDF : 8'h00);
      end
      out_en[9]              = 1'b0;
      out_cfg[9*CfgW +: CfgW] = 8'h20;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      next();
      next();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = '0;
      out_en    = '0;
      out_cfg   = '0;
      set_act(20'h00089);
      next();
      sample();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      next();
      reset = 1'b0;
      sample();
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_xfer", 32'(xfer_count), 32'd0);
      check("post_rst_valid", 32'(out_valid), 32'd0);

      // Single token to branches 0, 3, 7.
      out_ready = '1;
      in_valid  = 1'b1;
      in_data   = 17'h000A5;
      next();
      in_valid = 1'b0;
      sample();
      check("t1_valid", 32'(out_valid), 32'h89);
      check("t1_data", 32'(out_data), 32'hA5);
      next();
      sample();
      check("t1_popped", 32'(out_valid), 32'd0);
      check("t1_xfer", 32'(xfer_count), 32'd1);

      // Branch 3 stalls for 4 cycles while three tokens arrive.
      do_reset();
      out_ready = ~(20'h1 << 3);
      in_valid  = 1'b1;
      in_data   = 17'h10101;
      sample();
      check("t2_c1_ready", 32'(in_ready), 32'd1);
      next();
      in_data = 17'h00202;
      sample();
      check("t2_c2_valid", 32'(out_valid), 32'h89);
      check("t2_c2_data", 32'(out_data), 32'h10101);
      check("t2_c2_ready", 32'(in_ready), 32'd1);
      next();
      in_data = 17'h00303;
      sample();
      check("t2_c3_valid", 32'(out_valid), 32'h08);
      check("t2_c3_ready", 32'(in_ready), 32'd0);
      check("t2_c3_data", 32'(out_data), 32'h10101);
      next();
      sample();
      check("t2_c4_valid", 32'(out_valid), 32'h08);
      check("t2_c4_ready", 32'(in_ready), 32'd0);
      next();
      out_ready = '1;
      sample();
      check("t2_c5_valid", 32'(out_valid), 32'h08);
      next();
      sample();
      check("t2_c6_ready", 32'(in_ready), 32'd1);
      check("t2_c6_valid", 32'(out_valid), 32'h89);
      check("t2_c6_data", 32'(out_data), 32'h00202);
      next();
      in_valid = 1'b0;
      sample();
      check("t2_c7_data", 32'(out_data), 32'h00303);
      check("t2_c7_valid", 32'(out_valid), 32'h89);
      next();
      sample();
      check("t2_end_valid", 32'(out_valid), 32'd0);
      check("t2_xfer", 32'(xfer_count), 32'd3);

      // No participants: tokens are discarded one per cycle.
      do_reset();
      set_act('0);
      out_ready = '1;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 17'(k + 1);
         sample();
         check("t3_ready", 32'(in_ready), 32'd1);
         check("t3_valid", 32'(out_valid), 32'd0);
         next();
      end
      in_valid = 1'b0;
      sample();
      check("t3_last_valid", 32'(out_valid), 32'd0);
      next();
      sample();
      check("t3_xfer", 32'(xfer_count), 32'd5);

      // Dropping branch 3 while it is the only one pending pops the head.
      do_reset();
      set_act(20'h00089);
      out_ready = ~(20'h1 << 3);
      in_valid  = 1'b1;
      in_data   = 17'h00011;
      next();
      in_data = 17'h00022;
      sample();
      check("t4_c2_valid", 32'(out_valid), 32'h89);
      next();
      in_valid = 1'b0;
      set_act(20'h00081);
      sample();
      check("t4_drop_valid", 32'(out_valid), 32'd0);
      check("t4_drop_ready", 32'(in_ready), 32'd0);
      next();
      sample();
      check("t4_next_valid", 32'(out_valid), 32'h81);
      check("t4_next_data", 32'(out_data), 32'h00022);
      check("t4_xfer1", 32'(xfer_count), 32'd1);
      next();
      sample();
      check("t4_xfer2", 32'(xfer_count), 32'd2);
      check("t4_end_valid", 32'(out_valid), 32'd0);

      // Sustained streaming of 100 tokens.
      do_reset();
      set_act(20'h00089);
      out_ready = '1;
      for (int k = 0; k < 100; k++) begin
         in_valid = 1'b1;
         in_data  = 17'(32'h1000 + k);
         sample();
         check("t5_ready", 32'(in_ready), 32'd1);
         if (k > 0) begin
            check("t5_data", 32'(out_data), 32'h1000 + 32'(k - 1));
            check("t5_valid", 32'(out_valid), 32'h89);
         end
         next();
      end
      in_valid = 1'b0;
      sample();
      check("t5_last_data", 32'(out_data), 32'h1000 + 32'd99);
      next();
      sample();
      check("t5_xfer", 32'(xfer_count), 32'd100);
      check("t5_end_valid", 32'(out_valid), 32'd0);

      // Reset with two tokens buffered and nothing accepted yet.
      out_ready = '0;
      in_valid  = 1'b1;
      in_data   = 17'h00AAA;
      next();
      in_data = 17'h00BBB;
      sample();
      check("t6_c2_ready", 32'(in_ready), 32'd1);
      next();
      in_valid = 1'b0;
      sample();
      check("t6_full_ready", 32'(in_ready), 32'd0);
      check("t6_full_valid", 32'(out_valid), 32'h89);
      check("t6_pre_xfer", 32'(xfer_count), 32'd100);
      next();
      reset = 1'b1;
      sample();
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_ready", 32'(in_ready), 32'd0);
      next();
      sample();
      check("t6_rst2_valid", 32'(out_valid), 32'd0);
      check("t6_rst2_ready", 32'(in_ready), 32'd0);
      next();
      reset = 1'b0;
      sample();
      check("t6_rel_ready", 32'(in_ready), 32'd1);
      check("t6_rel_valid", 32'(out_valid), 32'd0);
      check("t6_rel_xfer", 32'(xfer_count), 32'd0);
      in_valid = 1'b1;
      in_data  = 17'h00CCC;
      next();
      in_valid = 1'b0;
      sample();
      check("t6_new_data", 32'(out_data), 32'h00CCC);
      check("t6_new_valid", 32'(out_valid), 32'h89);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
